// File: rtl/gimli_stream_msg_sequencer_if.sv
// Command, byte-stream, instruction and packed-word buses of the gimli_stream front-end sequencer.
`timescale 1ns/1ps
interface gimli_stream_msg_sequencer_if #(
  parameter int unsigned DIN_DOUT_WIDTH      = 32,
  parameter int unsigned DIN_DOUT_SIZE_WIDTH = 2
);
  logic [3:0]                     cmd;
  logic                           cmd_empty;
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [7:0]                     s_data;
  logic                           s_last;
  logic                           s_valid;
  logic                           s_ready;
  logic [3:0]                     inst;
  logic                           inst_valid;
  logic                           inst_ready;
  logic [DIN_DOUT_WIDTH-1:0]      din;
  logic [DIN_DOUT_SIZE_WIDTH:0]   din_size;
  logic                           din_last;
  logic                           din_valid;
  logic                           din_ready;

  modport master (
    input  cmd, cmd_empty, cmd_valid, s_data, s_last, s_valid, inst_ready, din_ready,
    output cmd_ready, s_ready, inst, inst_valid, din, din_size, din_last, din_valid
  );

  modport slave (
    output cmd, cmd_empty, cmd_valid, s_data, s_last, s_valid, inst_ready, din_ready,
    input  cmd_ready, s_ready, inst, inst_valid, din, din_size, din_last, din_valid
  );
endinterface

// File: rtl/gimli_stream_msg_sequencer.sv
// Turns one command plus a byte-serial message into one gimli_stream instruction and packed din words.
// Optional macro GIMLI_SEQ_ZERO_LEN_EN: commands flagged cmd_empty emit a single empty last word.
`timescale 1ns/1ps
module gimli_stream_msg_sequencer #(
  parameter int unsigned DIN_DOUT_WIDTH      = 32,
  parameter int unsigned DIN_DOUT_SIZE_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          arstn,
  gimli_stream_msg_sequencer_if.master  bus,
  output logic                          busy
);
  localparam int unsigned LANES  = DIN_DOUT_WIDTH / 8;
  localparam int unsigned SIZE_W = DIN_DOUT_SIZE_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_PACK, S_ZERO, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cmd_q;
  logic [SIZE_W-1:0]         cnt_q;
  logic [DIN_DOUT_WIDTH-1:0] pack_q, pack_next;
  logic                      out_valid_q, out_last_q;
  logic [DIN_DOUT_WIDTH-1:0] out_data_q;
  logic [SIZE_W-1:0]         out_size_q;
`ifdef GIMLI_SEQ_ZERO_LEN_EN
  logic                      empty_q;
`endif

  logic cmd_fire, inst_fire, byte_fire, din_fire, word_done, zero_load;

  assign cmd_fire  = bus.cmd_valid  && bus.cmd_ready;
  assign inst_fire = bus.inst_valid && bus.inst_ready;
  assign byte_fire = bus.s_valid    && bus.s_ready;
  assign din_fire  = bus.din_valid  && bus.din_ready;
  assign word_done = byte_fire && (bus.s_last || (cnt_q == SIZE_W'(LANES - 1)));
  assign zero_load = (state_q == S_ZERO) && (!out_valid_q || bus.din_ready);

  // State register
  always_ff @(posedge clk) begin
    if (!arstn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = S_ISSUE;
`ifdef GIMLI_SEQ_ZERO_LEN_EN
      S_ISSUE: if (inst_fire) state_d = empty_q ? S_ZERO : S_PACK;
`else
      S_ISSUE: if (inst_fire) state_d = S_PACK;
`endif
      S_PACK:  if (word_done && bus.s_last) state_d = S_DRAIN;
      S_ZERO:  if (zero_load) state_d = S_DRAIN;
      S_DRAIN: if (din_fire && out_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs; every ready/valid is held low while reset is asserted
  always_comb begin
    bus.cmd_ready  = 1'b0;
    bus.inst_valid = 1'b0;
    bus.s_ready    = 1'b0;
    bus.din_valid  = 1'b0;
    busy           = 1'b0;
    if (arstn) begin
      busy          = (state_q != S_IDLE);
      bus.din_valid = out_valid_q;
      case (state_q)
        S_IDLE:  bus.cmd_ready  = 1'b1;
        S_ISSUE: bus.inst_valid = 1'b1;
        S_PACK:  bus.s_ready    = !out_valid_q || bus.din_ready;
        default: ;
      endcase
    end
  end

  // Byte lane insertion at the current fill position
  always_comb begin
    pack_next = pack_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (cnt_q == SIZE_W'(i)) pack_next[8*i +: 8] = bus.s_data;
    end
  end

  // Command latch, pack register and output register
  always_ff @(posedge clk) begin
    if (!arstn) begin
      cmd_q       <= '0;
      cnt_q       <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_size_q  <= '0;
`ifdef GIMLI_SEQ_ZERO_LEN_EN
      empty_q     <= 1'b0;
`endif
    end else begin
      if (cmd_fire) begin
        cmd_q   <= bus.cmd;
`ifdef GIMLI_SEQ_ZERO_LEN_EN
        empty_q <= bus.cmd_empty;
`endif
      end
      if (word_done) begin
        cnt_q  <= '0;
        pack_q <= '0;
      end else if (byte_fire) begin
        cnt_q  <= cnt_q + SIZE_W'(1);
        pack_q <= pack_next;
      end
      // A load on the same edge as a drain keeps the register full
      if (word_done) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pack_next;
        out_size_q  <= cnt_q + SIZE_W'(1);
        out_last_q  <= bus.s_last;
      end else if (zero_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= '0;
        out_size_q  <= '0;
        out_last_q  <= 1'b1;
      end else if (din_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.inst     = cmd_q;
  assign bus.din      = out_data_q;
  assign bus.din_size = out_size_q;
  assign bus.din_last = out_last_q;
endmodule

// File: tb/tb_gimli_stream_msg_sequencer.sv
// Directed bench for gimli_stream_msg_sequencer with DIN_DOUT_WIDTH=32.
`timescale 1ns/1ps
module tb_gimli_stream_msg_sequencer;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  gimli_stream_msg_sequencer_if #(.DIN_DOUT_WIDTH(W), .DIN_DOUT_SIZE_WIDTH(SW)) bus ();

  gimli_stream_msg_sequencer #(.DIN_DOUT_WIDTH(W), .DIN_DOUT_SIZE_WIDTH(SW)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus),
    .busy  (busy)
  );

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0]  wq_din  [$];
  logic [SW:0]   wq_size [$];
  logic          wq_last [$];
  logic [3:0]    iq      [$];
  int            byte_cnt = 0;
  logic [7:0]    msg     [16];

  // Transfer monitor: inputs change just after posedge, so negedge sees settled handshakes
  always @(negedge clk) begin
    if (arstn) begin
      if (bus.din_valid && bus.din_ready) begin
        wq_din.push_back(bus.din);
        wq_size.push_back(bus.din_size);
        wq_last.push_back(bus.din_last);
      end
      if (bus.inst_valid && bus.inst_ready) iq.push_back(bus.inst);
      if (bus.s_valid && bus.s_ready) byte_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wq_din.delete();
    wq_size.delete();
    wq_last.delete();
    iq.delete();
  endtask

  task automatic do_cmd(input logic [3:0] c, input logic e);
    bit ok = 1'b0;
    bus.cmd       = c;
    bus.cmd_empty = e;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL cmd_accept: cmd_ready=0 for 20 cycles, required 1");
    end
  endtask

  task automatic send_msg(input int n, input bit with_last);
    bit all_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit ok = 1'b0;
      bus.s_data  = msg[i];
      bus.s_last  = with_last && (i == n - 1);
      bus.s_valid = 1'b1;
      for (int j = 0; j < 50 && !ok; j++) begin
        @(negedge clk);
        if (bus.s_ready) ok = 1'b1;
        tick();
      end
      if (!ok) all_ok = 1'b0;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    nvec++;
    if (!all_ok) begin
      nerr++;
      $display("FAIL byte_accept: s_ready stayed 0 for 50 cycles, required 1");
    end
  endtask

  task automatic wait_last();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.din_valid && bus.din_ready && bus.din_last) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL last_word: no din_last transfer in 100 cycles, required one");
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({bus.cmd_ready, bus.s_ready, bus.inst_valid, bus.din_valid, bus.din_last, busy} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: cmd_rdy/s_rdy/inst_v/din_v/last/busy=%b required 000000",
               {bus.cmd_ready, bus.s_ready, bus.inst_valid, bus.din_valid, bus.din_last, busy});
    end
    nvec++;
    if (bus.din !== '0 || bus.din_size !== '0 || bus.inst !== 4'h0) begin
      nerr++;
      $display("FAIL reset_data: din=%h size=%0d inst=%h required 0/0/0", bus.din, bus.din_size, bus.inst);
    end
    tick();
    arstn = 1'b1;
    @(negedge clk);
    nvec++;
    if (bus.cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_release: cmd_ready=%b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_four_bytes();
    tick();
    clear_q();
    do_cmd(4'h3, 1'b0);
    msg[0] = 8'h01; msg[1] = 8'h02; msg[2] = 8'h03; msg[3] = 8'h04;
    send_msg(4, 1'b1);
    wait_last();
    @(negedge clk);
    nvec++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL four_idle: cmd_ready=%b busy=%b required 1/0", bus.cmd_ready, busy);
    end
    nvec++;
    if (iq.size() != 1 || iq[0] !== 4'h3) begin
      nerr++;
      $display("FAIL four_inst: count=%0d inst=%h required 1/3", iq.size(), iq[0]);
    end
    nvec++;
    if (wq_din.size() != 1 || wq_din[0] !== 32'h04030201 || wq_size[0] !== 3'd4 || wq_last[0] !== 1'b1) begin
      nerr++;
      $display("FAIL four_word: n=%0d din=%h size=%0d last=%b required 1/04030201/4/1",
               wq_din.size(), wq_din[0], wq_size[0], wq_last[0]);
    end
  endtask

  task automatic test_six_bytes();
    tick();
    clear_q();
    do_cmd(4'h6, 1'b0);
    for (int i = 0; i < 6; i++) msg[i] = 8'(i + 1);
    send_msg(6, 1'b1);
    wait_last();
    @(negedge clk);
    nvec++;
    if (wq_din.size() != 2) begin
      nerr++;
      $display("FAIL six_count: words=%0d required 2", wq_din.size());
    end
    nvec++;
    if (wq_din[0] !== 32'h04030201 || wq_size[0] !== 3'd4 || wq_last[0] !== 1'b0) begin
      nerr++;
      $display("FAIL six_word0: din=%h size=%0d last=%b required 04030201/4/0", wq_din[0], wq_size[0], wq_last[0]);
    end
    nvec++;
    if (wq_din[1] !== 32'h00000605 || wq_size[1] !== 3'd2 || wq_last[1] !== 1'b1) begin
      nerr++;
      $display("FAIL six_word1: din=%h size=%0d last=%b required 00000605/2/1", wq_din[1], wq_size[1], wq_last[1]);
    end
  endtask

  task automatic test_backpressure();
    tick();
    clear_q();
    bus.din_ready = 1'b0;
    do_cmd(4'h9, 1'b0);
    for (int i = 0; i < 8; i++) msg[i] = 8'(8'h10 + i);
    fork
      send_msg(8, 1'b1);
      begin
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge clk);
          if (bus.din_valid) got = 1'b1;
        end
        nvec++;
        if (!got) begin
          nerr++;
          $display("FAIL bp_load: din_valid=0 for 50 cycles, required 1");
        end
        repeat (5) begin
          @(negedge clk);
          nvec++;
          if (bus.s_ready !== 1'b0 || bus.din_valid !== 1'b1 || bus.din !== 32'h13121110 ||
              bus.din_size !== 3'd4 || bus.din_last !== 1'b0) begin
            nerr++;
            $display("FAIL bp_stall: s_ready=%b valid=%b din=%h size=%0d last=%b required 0/1/13121110/4/0",
                     bus.s_ready, bus.din_valid, bus.din, bus.din_size, bus.din_last);
          end
        end
        tick();
        bus.din_ready = 1'b1;
      end
    join
    wait_last();
    @(negedge clk);
    nvec++;
    if (wq_din.size() != 2 || wq_din[0] !== 32'h13121110 || wq_size[0] !== 3'd4 || wq_last[0] !== 1'b0) begin
      nerr++;
      $display("FAIL bp_word0: n=%0d din=%h size=%0d last=%b required 2/13121110/4/0",
               wq_din.size(), wq_din[0], wq_size[0], wq_last[0]);
    end
    nvec++;
    if (wq_din[1] !== 32'h17161514 || wq_size[1] !== 3'd4 || wq_last[1] !== 1'b1) begin
      nerr++;
      $display("FAIL bp_word1: din=%h size=%0d last=%b required 17161514/4/1", wq_din[1], wq_size[1], wq_last[1]);
    end
  endtask

  task automatic test_inst_stall();
    tick();
    clear_q();
    bus.inst_ready = 1'b0;
    do_cmd(4'h5, 1'b0);
    msg[0] = 8'hA1;
    bus.s_data  = 8'hA1;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      nvec++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== 4'h5 || bus.s_ready !== 1'b0) begin
        nerr++;
        $display("FAIL inst_stall: inst_valid=%b inst=%h s_ready=%b required 1/5/0",
                 bus.inst_valid, bus.inst, bus.s_ready);
      end
    end
    tick();
    bus.inst_ready = 1'b1;
    send_msg(1, 1'b1);
    wait_last();
    @(negedge clk);
    nvec++;
    if (iq.size() != 1 || iq[0] !== 4'h5) begin
      nerr++;
      $display("FAIL stall_inst: count=%0d inst=%h required 1/5", iq.size(), iq[0]);
    end
    nvec++;
    if (wq_din.size() != 1 || wq_din[0] !== 32'h000000A1 || wq_size[0] !== 3'd1 || wq_last[0] !== 1'b1) begin
      nerr++;
      $display("FAIL stall_word: n=%0d din=%h size=%0d last=%b required 1/000000A1/1/1",
               wq_din.size(), wq_din[0], wq_size[0], wq_last[0]);
    end
  endtask

  task automatic test_zero_len();
    int b0;
    tick();
    clear_q();
    b0 = byte_cnt;
`ifdef GIMLI_SEQ_ZERO_LEN_EN
    do_cmd(4'h7, 1'b1);
    bus.s_data  = 8'h55;
    bus.s_last  = 1'b1;
    bus.s_valid = 1'b1;
    wait_last();
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    @(negedge clk);
    nvec++;
    if (wq_din.size() != 1 || wq_din[0] !== 32'h0 || wq_size[0] !== 3'd0 || wq_last[0] !== 1'b1) begin
      nerr++;
      $display("FAIL zero_word: n=%0d din=%h size=%0d last=%b required 1/00000000/0/1",
               wq_din.size(), wq_din[0], wq_size[0], wq_last[0]);
    end
    nvec++;
    if (byte_cnt - b0 != 0) begin
      nerr++;
      $display("FAIL zero_bytes: accepted=%0d required 0", byte_cnt - b0);
    end
`else
    do_cmd(4'h7, 1'b1);
    msg[0] = 8'hAA;
    send_msg(1, 1'b1);
    wait_last();
    @(negedge clk);
    nvec++;
    if (wq_din.size() != 1 || wq_din[0] !== 32'h000000AA || wq_size[0] !== 3'd1 || wq_last[0] !== 1'b1) begin
      nerr++;
      $display("FAIL zero_word: n=%0d din=%h size=%0d last=%b required 1/000000AA/1/1",
               wq_din.size(), wq_din[0], wq_size[0], wq_last[0]);
    end
    nvec++;
    if (byte_cnt - b0 != 1) begin
      nerr++;
      $display("FAIL zero_bytes: accepted=%0d required 1", byte_cnt - b0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    tick();
    clear_q();
    do_cmd(4'h2, 1'b0);
    msg[0] = 8'h33; msg[1] = 8'h44;
    send_msg(2, 1'b0);
    arstn = 1'b0;
    @(negedge clk);
    nvec++;
    if ({bus.cmd_ready, bus.s_ready, bus.inst_valid, bus.din_valid, busy} !== 5'b0) begin
      nerr++;
      $display("FAIL mid_reset: cmd_rdy/s_rdy/inst_v/din_v/busy=%b required 00000",
               {bus.cmd_ready, bus.s_ready, bus.inst_valid, bus.din_valid, busy});
    end
    tick();
    tick();
    arstn = 1'b1;
    @(negedge clk);
    nvec++;
    if (bus.cmd_ready !== 1'b1 || bus.din_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mid_release: cmd_ready=%b din_valid=%b required 1/0", bus.cmd_ready, bus.din_valid);
    end
    tick();
    do_cmd(4'h4, 1'b0);
    msg[0] = 8'h11; msg[1] = 8'h22;
    send_msg(2, 1'b1);
    wait_last();
    @(negedge clk);
    nvec++;
    if (wq_din.size() != 1 || wq_din[0] !== 32'h00002211 || wq_size[0] !== 3'd2 || wq_last[0] !== 1'b1) begin
      nerr++;
      $display("FAIL mid_word: n=%0d din=%h size=%0d last=%b required 1/00002211/2/1",
               wq_din.size(), wq_din[0], wq_size[0], wq_last[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd        = 4'h0;
    bus.cmd_empty  = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.s_data     = 8'h00;
    bus.s_last     = 1'b0;
    bus.s_valid    = 1'b0;
    bus.inst_ready = 1'b1;
    bus.din_ready  = 1'b1;
    test_reset();
    test_four_bytes();
    test_six_bytes();
    test_backpressure();
    test_inst_stall();
    test_zero_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
